pong_ctrl: RTL and testbench
============================

PONG_CTRL -- requirements
Module: pong_ctrl

Interface
REQ-001 Parameter BALLS, default 3, balls per game (1..3).
REQ-002 Parameter WAIT_TICKS, default 120, frame ticks in the post-miss/game-over wait (2 s at 60 Hz).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 refr_tick  input  1  one-cycle pulse per video frame.
REQ-006 btn  input  2  debounced player buttons, level.
REQ-007 hit  input  1  one-cycle pulse: ball struck paddle.
REQ-008 miss  input  1  one-cycle pulse: ball passed paddle.
REQ-009 gra_still  output  1  1 = graphics frozen/ball parked; 0 = ball moving.
REQ-010 text_en  output  4  overlay enables {score, logo, rule, over}.
REQ-011 dig1, dig0  output  4 each  BCD score tens/units.
REQ-012 ball  output  2  balls remaining after the current one.
REQ-013 state  output  2  FSM state code for debug.

Function
REQ-014 FSM states SHALL be NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3, registered, one transition per cycle max.
REQ-015 NEWGAME: ball held at BALLS-1, score held at 00; btn!=0 SHALL go to PLAY next cycle.
REQ-016 PLAY: miss with ball==0 SHALL go to OVER; miss with ball>0 SHALL go to NEWBALL and decrement ball; both load the wait timer.
REQ-017 NEWBALL: when timer expired and btn!=0 SHALL go to PLAY; btn before expiry SHALL be ignored.
REQ-018 OVER: when timer expired SHALL go to NEWGAME, clearing score and reloading ball to BALLS-1.
REQ-019 Wait timer SHALL load WAIT_TICKS-1 on entry to NEWBALL/OVER, decrement only on refr_tick, saturate at 0; expired = (count==0) and not loading this cycle.
REQ-020 Timer width SHALL be clog2(WAIT_TICKS); WAIT_TICKS==1 gives expiry one cycle after entry.
REQ-021 Score SHALL increment by one on hit only in PLAY; units 9 wraps to 0 with tens carry; 99 wraps to 00.
REQ-022 hit and miss in same PLAY cycle: score increments and miss transition both apply.
REQ-023 hit/miss outside PLAY SHALL be ignored.
REQ-024 gra_still SHALL be 0 in PLAY only, combinational from state.
REQ-025 text_en: score always 1; logo and rule 1 in NEWGAME; over 1 in OVER; else 0.

Reset
REQ-026 reset low SHALL asynchronously force state=NEWGAME, ball=BALLS-1, dig1=dig0=0, timer=0.
REQ-027 After reset release, first evaluation SHALL occur on the next rising clk; reset mid-PLAY or mid-wait discards score and timer.

Structure
REQ-028 State encodings and BCD digit width SHALL live in shared package pong_pkg.
REQ-029 One sub-module, pong_ctrl_timer (loadable tick down-counter with expired flag), is natural; BCD score counter stays inline.
REQ-030 No combinational path from hit/miss/btn to any output.

Verification
REQ-031 Reset low, then high; btn=01 one cycle -> state=1, gra_still=0, ball=2, score 00.
REQ-032 In PLAY, 12 hit pulses -> dig1=1, dig0=2; 100 hits from 00 -> 00.
REQ-033 miss with ball=2 -> state=2, ball=1; btn held during wait ignored; after 120 refr_ticks plus btn -> state=1.
REQ-034 Three misses across game -> state=3, text_en=1001; 120 refr_ticks -> state=0, score 00, text_en=1110.
REQ-035 hit and miss same cycle at score 05, ball=0 -> state=3, dig0=6.
REQ-036 reset low mid-NEWBALL wait at score 37 -> immediately state=0, score 00, ball=2.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong game controller: FSM encodings and BCD helpers.
package pong_pkg;

    // Width of one BCD score digit.
    localparam int unsigned DigW = 4;

    typedef logic [DigW-1:0] bcd_t;

    // FSM state encodings (also exported on the debug state port).
    localparam logic [1:0] StNewgame = 2'd0;
    localparam logic [1:0] StPlay    = 2'd1;
    localparam logic [1:0] StNewball = 2'd2;
    localparam logic [1:0] StOver    = 2'd3;

    // Two-digit BCD increment, 99 wraps to 00. Returns {tens, units}.
    function automatic logic [2*DigW-1:0] bcd_inc(input bcd_t tens, input bcd_t units);
        bcd_t tens_n;
        bcd_t units_n;
        tens_n  = tens;
        units_n = units + DigW'(1);
        if (units == DigW'(9)) begin
            units_n = '0;
            tens_n  = (tens == DigW'(9)) ? '0 : tens + DigW'(1);
        end
        return {tens_n, units_n};
    endfunction

endpackage

// File: rtl/pong_ctrl_timer.sv
// Loadable frame-tick down-counter used for the post-miss and game-over waits.
module pong_ctrl_timer #(
    parameter int unsigned WAIT_TICKS = 120
) (
    input  logic clk,
    input  logic reset,     // asynchronous, active low
    input  logic load,      // reload to WAIT_TICKS-1 this cycle
    input  logic tick,      // one pulse per video frame
    output logic expired
);

    // WAIT_TICKS of 1 would give a zero-width counter; keep at least one bit.
    localparam int unsigned CntW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(WAIT_TICKS - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] count_d, count_q;

    // Next count: load wins, otherwise decrement on a frame tick, saturating at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LoadVal;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - CntOne;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load in flight masks the stale zero left from the previous wait.
    assign expired = (count_q == '0) && !load;

endmodule

// File: rtl/pong_ctrl.sv
// Pong game controller: game-flow FSM, BCD score keeping and ball bookkeeping.
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS      = 3,
    parameter int unsigned WAIT_TICKS = 120
) (
    input  logic            clk,
    input  logic            reset,      // asynchronous, active low
    input  logic            refr_tick,
    input  logic [1:0]      btn,
    input  logic            hit,
    input  logic            miss,
    output logic            gra_still,
    output logic [3:0]      text_en,    // {score, logo, rule, over}
    output logic [DigW-1:0] dig1,
    output logic [DigW-1:0] dig0,
    output logic [1:0]      ball,
    output logic [1:0]      state
);

    localparam logic [1:0] BallInit = 2'(BALLS - 1);

    logic [1:0] state_d, state_q;
    logic [1:0] ball_d, ball_q;
    bcd_t       dig1_d, dig1_q;
    bcd_t       dig0_d, dig0_q;
    logic       tmr_load;
    logic       tmr_expired;

    pong_ctrl_timer #(
        .WAIT_TICKS(WAIT_TICKS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .tick    (refr_tick),
        .expired (tmr_expired)
    );

    // Game-flow next state, score and ball count.
    always_comb begin
        state_d  = state_q;
        ball_d   = ball_q;
        dig1_d   = dig1_q;
        dig0_d   = dig0_q;
        tmr_load = 1'b0;
        case (state_q)
            StNewgame: begin
                ball_d = BallInit;
                dig1_d = '0;
                dig0_d = '0;
                if (btn != 2'b00) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // A hit and a miss in the same cycle both take effect.
                if (hit) begin
                    {dig1_d, dig0_d} = bcd_inc(dig1_q, dig0_q);
                end
                if (miss) begin
                    tmr_load = 1'b1;
                    if (ball_q == 2'd0) begin
                        state_d = StOver;
                    end else begin
                        state_d = StNewball;
                        ball_d  = ball_q - 2'd1;
                    end
                end
            end
            StNewball: begin
                if (tmr_expired && (btn != 2'b00)) begin
                    state_d = StPlay;
                end
            end
            StOver: begin
                if (tmr_expired) begin
                    state_d = StNewgame;
                    ball_d  = BallInit;
                    dig1_d  = '0;
                    dig0_d  = '0;
                end
            end
            default: begin
                state_d = StNewgame;
            end
        endcase
    end

    // State, score and ball registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StNewgame;
            ball_q  <= BallInit;
            dig1_q  <= '0;
            dig0_q  <= '0;
        end else begin
            state_q <= state_d;
            ball_q  <= ball_d;
            dig1_q  <= dig1_d;
            dig0_q  <= dig0_d;
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        gra_still = (state_q != StPlay);
        text_en   = {1'b1, (state_q == StNewgame), (state_q == StNewgame), (state_q == StOver)};
        dig1      = dig1_q;
        dig0      = dig0_q;
        ball      = ball_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// Scoreboard bench for pong_ctrl: stimulus queues expected snapshots, a monitor compares them.
module tb_pong_ctrl;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       refr_tick = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [3:0] text_en;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [1:0] ball;
    logic [1:0] state;

    pong_ctrl #(
        .BALLS      (3),
        .WAIT_TICKS (120)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .refr_tick (refr_tick),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .gra_still (gra_still),
        .text_en   (text_en),
        .dig1      (dig1),
        .dig0      (dig0),
        .ball      (ball),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] ball;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] ten;
        logic       gs;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    vec_cnt = 0;
    int    err_cnt = 0;

    // Monitor: on every falling edge, compare the oldest pending expectation.
    initial begin : monitor
        snap_t e;
        snap_t a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {state, ball, dig1, dig0, text_en, gra_still};
                vec_cnt++;
                if (a !== e) begin
                    err_cnt++;
                    $display("FAIL %s: got st=%0d ball=%0d score=%0d%0d text_en=%b still=%b, expected st=%0d ball=%0d score=%0d%0d text_en=%b still=%b",
                             n, a.st, a.ball, a.d1, a.d0, a.ten, a.gs,
                             e.st, e.ball, e.d1, e.d0, e.ten, e.gs);
                end
            end
        end
    end

    // Advance past one rising edge; inputs change well away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Queue an expected snapshot; overlay and freeze values are hand-set per state.
    task automatic check(input string n, input logic [1:0] st, input logic [1:0] b,
                         input logic [3:0] d1, input logic [3:0] d0);
        snap_t e;
        e.st   = st;
        e.ball = b;
        e.d1   = d1;
        e.d0   = d0;
        case (st)
            2'd0:    e.ten = 4'b1110;
            2'd3:    e.ten = 4'b1001;
            default: e.ten = 4'b1000;
        endcase
        e.gs = (st != 2'd1);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        #1;
    endtask

    task automatic hits(input int n);
        hit = 1'b1;
        repeat (n) step();
        hit = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            refr_tick = 1'b1;
            step();
            refr_tick = 1'b0;
            step();
        end
    endtask

    // Miss, sit out the full wait, then relaunch with a button.
    task automatic miss_wait_resume();
        miss = 1'b1;
        step();
        miss = 1'b0;
        wait_ticks(119);
        step();
        btn = 2'b01;
        step();
        btn = 2'b00;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #12;
        check("reset", 2'd0, 2'd2, 4'd0, 4'd0);
        reset = 1'b1;
        step();
        check("idle", 2'd0, 2'd2, 4'd0, 4'd0);
        btn = 2'b01;
        step();
        btn = 2'b00;
        check("start", 2'd1, 2'd2, 4'd0, 4'd0);

        hits(12);
        check("hit12", 2'd1, 2'd2, 4'd1, 4'd2);
        hits(87);
        check("hit99", 2'd1, 2'd2, 4'd9, 4'd9);
        hits(1);
        check("wrap00", 2'd1, 2'd2, 4'd0, 4'd0);
        hits(37);
        check("score37", 2'd1, 2'd2, 4'd3, 4'd7);

        miss = 1'b1;
        step();
        miss = 1'b0;
        check("miss1", 2'd2, 2'd1, 4'd3, 4'd7);
        // Button held and a stray hit during the wait must be ignored.
        btn = 2'b01;
        hits(1);
        wait_ticks(118);
        check("wait118", 2'd2, 2'd1, 4'd3, 4'd7);
        refr_tick = 1'b1;
        step();
        refr_tick = 1'b0;
        check("wait119", 2'd2, 2'd1, 4'd3, 4'd7);
        btn = 2'b00;
        step();
        check("expired_nobtn", 2'd2, 2'd1, 4'd3, 4'd7);
        btn = 2'b10;
        step();
        btn = 2'b00;
        check("resume", 2'd1, 2'd1, 4'd3, 4'd7);

        // Asynchronous reset in the middle of a new-ball wait.
        miss = 1'b1;
        step();
        miss = 1'b0;
        wait_ticks(5);
        reset = 1'b0;
        #1;
        check("reset_midwait", 2'd0, 2'd2, 4'd0, 4'd0);
        reset = 1'b1;

        btn = 2'b11;
        step();
        btn = 2'b00;
        check("start2", 2'd1, 2'd2, 4'd0, 4'd0);
        hits(5);
        miss_wait_resume();
        check("g2_ball1", 2'd1, 2'd1, 4'd0, 4'd5);
        miss_wait_resume();
        check("g2_ball0", 2'd1, 2'd0, 4'd0, 4'd5);

        hit  = 1'b1;
        miss = 1'b1;
        step();
        hit  = 1'b0;
        miss = 1'b0;
        check("hit_miss_over", 2'd3, 2'd0, 4'd0, 4'd6);
        hit  = 1'b1;
        miss = 1'b1;
        step();
        hit  = 1'b0;
        miss = 1'b0;
        check("over_ignore", 2'd3, 2'd0, 4'd0, 4'd6);
        wait_ticks(118);
        check("over118", 2'd3, 2'd0, 4'd0, 4'd6);
        refr_tick = 1'b1;
        step();
        refr_tick = 1'b0;
        check("over119", 2'd3, 2'd0, 4'd0, 4'd6);
        step();
        check("newgame", 2'd0, 2'd2, 4'd0, 4'd0);
        hit  = 1'b1;
        miss = 1'b1;
        step();
        hit  = 1'b0;
        miss = 1'b0;
        check("newgame_ignore", 2'd0, 2'd2, 4'd0, 4'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
